// File: rtl/csr_counter_unit_pkg.sv
// Shared definitions for the counter CSR block: op codes, CSR addresses,
// counter-to-address offsets and mcountinhibit bit positions.
package csr_counter_unit_pkg;

  typedef enum logic [2:0] {
    CSR_OP_NONE    = 3'd0,
    CSR_OP_RW      = 3'd1,
    CSR_OP_RS      = 3'd2,
    CSR_OP_RC      = 3'd3,
    CSR_OP_RWI     = 3'd4,
    CSR_OP_RSI     = 3'd5,
    CSR_OP_RCI     = 3'd6,
    CSR_OP_ILLEGAL = 3'd7
  } csr_op_e;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_HALF_HI       = 12'h080;

  localparam logic [4:0] CNT_OFF_CYCLE   = 5'd0;
  localparam logic [4:0] CNT_OFF_TIME    = 5'd1;
  localparam logic [4:0] CNT_OFF_INSTRET = 5'd2;
  localparam logic [4:0] CNT_OFF_HPM3    = 5'd3;

  localparam int unsigned INH_CY   = 0;
  localparam int unsigned INH_IR   = 2;
  localparam int unsigned INH_HPM3 = 3;

  // Counter index 0 = cycle, 1 = instret, 2+k = hpmcounter(3+k).
  function automatic logic [4:0] counter_offset(int unsigned idx);
    if (idx == 0) return CNT_OFF_CYCLE;
    else if (idx == 1) return CNT_OFF_INSTRET;
    else return CNT_OFF_HPM3 + 5'(idx - 2);
  endfunction

  function automatic int unsigned inhibit_bit(int unsigned idx);
    if (idx == 0) return INH_CY;
    else if (idx == 1) return INH_IR;
    else return INH_HPM3 + idx - 2;
  endfunction

endpackage

// File: rtl/csr_counter_unit_counter64.sv
// One 64-bit event counter; a half write in a cycle takes priority over
// that cycle's increment.
module csr_counter64 #(
  parameter int CNT_W  = 64,
  parameter int HALF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              inhibit_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [HALF_W-1:0] wdata_i,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d = {cnt_q[CNT_W-1:HALF_W], wdata_i};
    end else if (wr_hi_i) begin
      cnt_d = {wdata_i, cnt_q[HALF_W-1:0]};
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_counter_unit.sv
// Zicntr/Zihpm counter CSR block: address decode, read-modify-write data,
// read mux and illegal-access detection around 2+NUM_HPM counters.
module csr_counter_unit
  import csr_counter_unit_pkg::*;
#(
  parameter int CSR_XLEN       = 64,
  parameter int REG_XLEN       = 32,
  parameter int CSR_OP_WIDTH   = 3,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int NUM_HPM        = 4,
  localparam int HPM_W         = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CSR_OP_WIDTH-1:0]   csr_op_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [REG_XLEN-1:0]       csr_val_i,
  output logic [REG_XLEN-1:0]       csr_val_o,
  output logic                      csr_illegal_o,
  input  logic                      instret_i,
  input  logic [HPM_W-1:0]          hpm_event_i
);

  localparam int NUM_CNT = 2 + NUM_HPM;
  localparam int IDX_W   = $clog2(NUM_CNT);

  logic [CSR_XLEN-1:0]       cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0]        cnt_inc;
  logic [NUM_CNT-1:0]        cnt_inh;
  logic [NUM_CNT-1:0]        cnt_wr_lo;
  logic [NUM_CNT-1:0]        cnt_wr_hi;
  logic [REG_XLEN-1:0]       inhibit_q;
  logic [REG_XLEN-1:0]       inhibit_d;
  logic [REG_XLEN-1:0]       inhibit_mask;

  logic [CSR_ADDR_WIDTH-1:0] addr_lo;
  logic                      sel_hi;
  logic                      sel_inh;
  logic                      is_shadow;
  logic                      hit;
  logic [IDX_W-1:0]          sel;
  logic [REG_XLEN-1:0]       old_val;
  logic [REG_XLEN-1:0]       wdata;
  logic                      is_write;
  logic                      op_none;
  logic                      illegal;
  logic                      do_write;
  csr_op_e                   op;

  assign op = csr_op_e'(csr_op_i);

  // Address decode: the high-half bit is stripped so each counter matches once.
  always_comb begin
    addr_lo   = csr_addr_i & ~CSR_HALF_HI;
    sel_hi    = (csr_addr_i & CSR_HALF_HI) != '0;
    is_shadow = csr_addr_i[11:8] == CSR_CYCLE[11:8];
    hit       = 1'b0;
    sel_inh   = 1'b0;
    sel       = '0;
    if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
      hit     = 1'b1;
      sel_inh = 1'b1;
    end
    if (addr_lo == CSR_CYCLE + {7'b0, CNT_OFF_TIME}) begin
      hit = 1'b1;
      sel = '0;
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (addr_lo == CSR_MCYCLE + {7'b0, counter_offset(i)} ||
          addr_lo == CSR_CYCLE + {7'b0, counter_offset(i)}) begin
        hit = 1'b1;
        sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    old_val = '0;
    if (sel_inh) begin
      old_val = inhibit_q;
    end else if (sel_hi) begin
      old_val = cnt_val[sel][CSR_XLEN-1:REG_XLEN];
    end else begin
      old_val = cnt_val[sel][REG_XLEN-1:0];
    end
  end

  // Set/clear with a zero operand is a pure read and stays legal on shadows.
  always_comb begin
    wdata    = csr_val_i;
    is_write = 1'b0;
    unique case (op)
      CSR_OP_RW, CSR_OP_RWI: begin
        wdata    = csr_val_i;
        is_write = 1'b1;
      end
      CSR_OP_RS, CSR_OP_RSI: begin
        wdata    = old_val | csr_val_i;
        is_write = csr_val_i != '0;
      end
      CSR_OP_RC, CSR_OP_RCI: begin
        wdata    = old_val & ~csr_val_i;
        is_write = csr_val_i != '0;
      end
      default: begin
        wdata    = csr_val_i;
        is_write = 1'b0;
      end
    endcase
  end

  assign op_none  = op == CSR_OP_NONE;
  assign illegal  = (op == CSR_OP_ILLEGAL) ||
                    (!op_none && !hit) ||
                    (!op_none && is_write && is_shadow);
  assign do_write = !op_none && !illegal && is_write;

  assign csr_val_o     = (!op_none && !illegal) ? old_val : '0;
  assign csr_illegal_o = illegal;

  for (genvar gi = 0; gi < REG_XLEN; gi++) begin : g_inh_mask
    assign inhibit_mask[gi] = (gi == INH_CY) || (gi == INH_IR) ||
                              (gi >= INH_HPM3 && gi < INH_HPM3 + NUM_HPM);
  end

  assign inhibit_d = (do_write && sel_inh) ? (wdata & inhibit_mask) : inhibit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= '0;
    end else begin
      inhibit_q <= inhibit_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    if (gi == 0) begin : g_cycle
      assign cnt_inc[gi] = 1'b1;
    end else if (gi == 1) begin : g_instret
      assign cnt_inc[gi] = instret_i;
    end else begin : g_hpm
      assign cnt_inc[gi] = hpm_event_i[gi-2];
    end

    // Increments always see the inhibit value from before this edge.
    assign cnt_inh[gi]   = inhibit_q[inhibit_bit(gi)];
    assign cnt_wr_lo[gi] = do_write && !sel_inh && (sel == IDX_W'(gi)) && !sel_hi;
    assign cnt_wr_hi[gi] = do_write && !sel_inh && (sel == IDX_W'(gi)) && sel_hi;

    csr_counter64 #(
      .CNT_W  (CSR_XLEN),
      .HALF_W (REG_XLEN)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (cnt_inc[gi]),
      .inhibit_i (cnt_inh[gi]),
      .wr_lo_i   (cnt_wr_lo[gi]),
      .wr_hi_i   (cnt_wr_hi[gi]),
      .wdata_i   (wdata),
      .cnt_o     (cnt_val[gi])
    );
  end

  if (NUM_HPM == 0) begin : g_no_hpm
    logic unused_hpm_event;
    assign unused_hpm_event = ^hpm_event_i;
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever an access is presented.
module tb_csr_counter_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_val_i;
  logic [31:0] csr_val_o;
  logic        csr_illegal_o;
  logic        instret_i;
  logic [3:0]  hpm_event_i;

  typedef struct {
    logic [31:0] val;
    logic        ill;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [2:0] OP_NONE = 3'd0, OP_RW = 3'd1, OP_RS = 3'd2, OP_RC = 3'd3,
                         OP_BAD = 3'd7;

  csr_counter_unit dut (
    .clk           (clk),
    .rst           (rst),
    .csr_op_i      (csr_op_i),
    .csr_addr_i    (csr_addr_i),
    .csr_val_i     (csr_val_i),
    .csr_val_o     (csr_val_o),
    .csr_illegal_o (csr_illegal_o),
    .instret_i     (instret_i),
    .hpm_event_i   (hpm_event_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] val,
                     input logic [31:0] ev, input logic ei, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    csr_op_i   = op;
    csr_addr_i = addr;
    csr_val_i  = val;
    e.val  = ev;
    e.ill  = ei;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      csr_op_i  = OP_NONE;
      csr_val_i = '0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (csr_op_i != OP_NONE) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_access: csr_val_o=%h csr_illegal_o=%b, no response was expected",
                 csr_val_o, csr_illegal_o);
      end else begin
        e = exp_q.pop_front();
        if (csr_val_o !== e.val || csr_illegal_o !== e.ill) begin
          n_fail++;
          $display("FAIL %s: got val=%h illegal=%b, expected val=%h illegal=%b",
                   e.name, csr_val_o, csr_illegal_o, e.val, e.ill);
        end else begin
          $display("ok   %s: op=%0d addr=%h val=%h illegal=%b",
                   e.name, csr_op_i, csr_addr_i, csr_val_o, csr_illegal_o);
        end
      end
    end else if (!rst) begin
      n_checks++;
      if (csr_val_o !== 32'h0 || csr_illegal_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_outputs: got val=%h illegal=%b, expected val=0 illegal=0",
                 csr_val_o, csr_illegal_o);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    csr_op_i    = OP_NONE;
    csr_addr_i  = '0;
    csr_val_i   = '0;
    instret_i   = 1'b0;
    hpm_event_i = 4'b0000;

    // Reset for three edges; counters read zero while held.
    csr(OP_RS, 12'hC00, 32'h0, 32'h0, 1'b0, "reset_cycle");
    idle(1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ten counted edges after release.
    idle(9);
    csr(OP_RS, 12'hC00, 32'h0, 32'd10, 1'b0, "cycle_after_10");
    csr(OP_RS, 12'hC80, 32'h0, 32'd0, 1'b0, "cycleh_after_10");

    // Wrap through all-ones.
    csr(OP_RW, 12'hB00, 32'hFFFF_FFFF, 32'd12, 1'b0, "wr_mcycle_lo");
    csr(OP_RW, 12'hB80, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_mcycle_hi");
    csr(OP_RS, 12'hC80, 32'h0, 32'hFFFF_FFFF, 1'b0, "cycleh_all_ones");
    csr(OP_RS, 12'hC00, 32'h0, 32'h0, 1'b0, "cycle_wrapped_lo");
    csr(OP_RS, 12'hC80, 32'h0, 32'h0, 1'b0, "cycle_wrapped_hi");

    // Low-half carry into the high half.
    csr(OP_RW, 12'hB00, 32'hFFFF_FFFE, 32'd2, 1'b0, "wr_mcycle_lo_fffe");
    csr(OP_RS, 12'hB00, 32'h0, 32'hFFFF_FFFE, 1'b0, "mcycle_lo_written");
    csr(OP_RS, 12'hC80, 32'h0, 32'd0, 1'b0, "cycleh_before_carry");
    csr(OP_RS, 12'hC80, 32'h0, 32'd1, 1'b0, "cycleh_after_carry");
    csr(OP_RS, 12'hC00, 32'h0, 32'd1, 1'b0, "cycle_lo_after_carry");

    // Inhibit CY and IR; the write cycle itself still counts.
    csr(OP_RW, 12'h320, 32'h5, 32'h0, 1'b0, "wr_inhibit");
    instret_i = 1'b1;
    csr(OP_RS, 12'hC02, 32'h0, 32'd1, 1'b0, "instret_write_cycle");
    csr(OP_RS, 12'hC00, 32'h0, 32'd3, 1'b0, "cycle_frozen_a");
    csr(OP_RS, 12'h320, 32'h0, 32'h5, 1'b0, "rd_inhibit");
    csr(OP_RS, 12'hB02, 32'h0, 32'd1, 1'b0, "minstret_frozen");
    csr(OP_RS, 12'hC01, 32'h0, 32'd3, 1'b0, "time_frozen");
    csr(OP_RC, 12'h320, 32'h5, 32'h5, 1'b0, "clr_inhibit");
    csr(OP_RS, 12'hC00, 32'h0, 32'd3, 1'b0, "cycle_frozen_clr_edge");
    csr(OP_RS, 12'hC00, 32'h0, 32'd4, 1'b0, "cycle_resumed");
    csr(OP_RS, 12'hC02, 32'h0, 32'd3, 1'b0, "instret_resumed");

    // Write beats a same-cycle retirement.
    csr(OP_RW, 12'hB02, 32'h100, 32'd4, 1'b0, "wr_minstret");
    csr(OP_RS, 12'hC02, 32'h0, 32'h100, 1'b0, "minstret_write_wins");
    instret_i = 1'b0;
    csr(OP_RS, 12'hC82, 32'h0, 32'h0, 1'b0, "instreth");

    // Illegal accesses.
    csr(OP_RW, 12'hC02, 32'h1, 32'h0, 1'b1, "wr_shadow_illegal");
    csr(OP_RS, 12'hC02, 32'h0, 32'h100, 1'b0, "shadow_unchanged");
    csr(OP_RW, 12'hC00, 32'h1, 32'h0, 1'b1, "wr_cycle_illegal");
    csr(OP_RS, 12'hB07, 32'h1, 32'h0, 1'b1, "unmapped_b07");
    csr(OP_RS, 12'hB01, 32'h0, 32'h0, 1'b1, "unmapped_b01");
    csr(OP_RS, 12'h321, 32'h0, 32'h0, 1'b1, "unmapped_321");
    csr(OP_BAD, 12'hB02, 32'h0, 32'h0, 1'b1, "op7_illegal");
    csr(OP_RC, 12'hC02, 32'h0, 32'h100, 1'b0, "rc_zero_shadow_read");
    csr(OP_RS, 12'hC02, 32'h1, 32'h0, 1'b1, "rs_nonzero_shadow");

    // HPM events on counters 1 and 3 for eight edges.
    hpm_event_i = 4'b1010;
    idle(7);
    csr(OP_RS, 12'hB04, 32'h0, 32'd8, 1'b0, "hpm4_count");
    hpm_event_i = 4'b0000;
    csr(OP_RS, 12'hB06, 32'h0, 32'd8, 1'b0, "hpm6_count");
    csr(OP_RS, 12'hB03, 32'h0, 32'd0, 1'b0, "hpm3_idle");
    csr(OP_RS, 12'hB05, 32'h0, 32'd0, 1'b0, "hpm5_idle");
    csr(OP_RS, 12'hC06, 32'h0, 32'd8, 1'b0, "hpmcounter6_shadow");
    csr(OP_RS, 12'hC84, 32'h0, 32'd0, 1'b0, "hpmcounter4h");

    // Only implemented inhibit bits are writable.
    csr(OP_RW, 12'h320, 32'h10, 32'h0, 1'b0, "wr_inhibit_hpm4");
    csr(OP_RS, 12'h320, 32'hFFFF_FFFF, 32'h10, 1'b0, "set_inhibit_all");
    csr(OP_RS, 12'h320, 32'h0, 32'h7D, 1'b0, "inhibit_mask");

    // Reset during a write discards the write.
    csr(OP_RW, 12'hB02, 32'h55, 32'h100, 1'b0, "wr_during_reset");
    rst = 1'b1;
    csr(OP_RS, 12'hC02, 32'h0, 32'h0, 1'b0, "minstret_after_reset");
    rst = 1'b0;
    csr(OP_RS, 12'h320, 32'h0, 32'h0, 1'b0, "inhibit_after_reset");
    idle(2);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
